mem_dbus_ctrl: RTL and testbench
================================

# mem_dbus_ctrl

Data-bus controller for the MEM stage. It turns the MEM-stage load/store request (address, store data, access size) into a single-outstanding valid/ready transaction on the data-memory bus, and stalls the pipeline until the bus responds. It generates byte enables and store-data lanes, and aligns and sign/zero-extends load data. It feeds the loaded word to the MEM/WB boundary and flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles spent in REQ+RSP before the access is aborted as a bus error; range 1..255.
- `i_clk`  in  1  single core clock; all logic rises on this edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_memAddr`  in  32  byte address from the ALU result.
- `i_wrData`  in  32  store data, unshifted; byte/half data sits in the low bits.
- `i_memRead`  in  1  load request.
- `i_memWrite`  in  1  store request; takes priority if asserted together with `i_memRead`.
- `i_funct3`  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- `o_readData`  out  32  aligned and extended load result.
- `o_stall`  out  1  holds the pipeline (PC, IF/ID, ID/EX, EX/MEM) while high.
- `o_misaligned`  out  1  access rejected because it is misaligned or has an unsupported funct3.
- `o_busErr`  out  1  single-cycle pulse when an access is aborted by timeout.
- `m_valid`, `m_write`  out  1 each  request valid; 1 = write.
- `m_addr`  out  32  word address; bits [1:0] are always 0.
- `m_wdata`  out  32  store data replicated into the byte lanes.
- `m_be`  out  4  byte enables; 4'b0000 on reads.
- `m_ready`  in  1  request accepted.
- `m_rvalid`  in  1  response valid; also the write acknowledge.
- `m_rdata`  in  32  read word.

## Operation
- FSM states are IDLE, REQ, RSP and DONE. Reset puts the FSM in IDLE.
- In IDLE, an access is `i_memRead | i_memWrite`.
- **Invalid access** (H at addr[0]=1, W at addr[1:0]≠0, funct3 outside the list, or BU/HU on a store):
  - `o_misaligned` = 1 combinationally.
  - `o_stall` = 0.
  - No bus transaction; stay in IDLE.
- **Valid access:**
  - `o_stall` = 1 combinationally.
  - Register the word address, `m_be`, `m_wdata`, `m_write`, funct3 and addr[1:0].
  - Go to REQ.
- **REQ:**
  - `m_valid` = 1, and request fields are stable until `m_valid & m_ready`.
  - On handshake, go to RSP.
- **RSP:** wait for `m_rvalid`.
  - On a read, latch the aligned result into `o_readData`.
  - Go to DONE.
- **Timeout:**
  - An 8-bit counter clears on entry to REQ and increments every cycle in REQ or RSP.
  - When the counter reaches `TIMEOUT_CYCLES` with no completion, go to DONE, drop `m_valid`, and force `o_readData` = 0 on reads.
  - `o_busErr` = 1 during that DONE cycle.
- **DONE:**
  - `o_stall` = 0 so the pipeline advances exactly once.
  - Unconditionally go to IDLE.
  - DONE never starts a new access.
- **Store lanes:**
  - B: `m_wdata` = {4{wrData[7:0]}}, `m_be` = 0001 << addr[1:0].
  - H: `m_wdata` = {2{wrData[15:0]}}, `m_be` = 0011 << addr[1:0].
  - W: `m_wdata` = wrData, `m_be` = 1111.
- **Load align:** shift `m_rdata` right by 8·addr[1:0].
  - B/H: sign-extend bit 7 or bit 15.
  - BU/HU: zero-extend.
  - W: pass through.
- `o_readData` holds its value until the next completed load. Stores and invalid accesses do not change it.
- `m_rvalid` outside RSP is ignored.

## Timing
- **Reset values:** state IDLE, `o_readData` 0, `m_valid` 0, `m_write` 0, `m_addr` 0, `m_wdata` 0, `m_be` 0, timeout counter 0, `o_busErr` 0.
- `o_stall` and `o_misaligned` are combinational from state and inputs, so they are 0 while in reset.
- **Zero-wait bus:**
  - cycle 0: IDLE sees the access.
  - cycle 1: REQ, `m_ready` = 1.
  - cycle 2: RSP, `m_rvalid` = 1.
  - cycle 3: DONE, `o_readData` valid and `o_stall` = 0.
  - Result: 3 stall cycles; the pipeline advances on the edge ending cycle 3.
- Each wait cycle on `m_ready` or `m_rvalid` adds exactly one stall cycle.
- `m_ready` and `m_rvalid` arriving in the same cycle while in REQ: only the handshake counts, and the response is expected in RSP from the next cycle.
- Reset asserted mid-transaction:
  - `m_valid` drops asynchronously and the FSM returns to IDLE.
  - The in-flight response is discarded.
- Timeout boundary: `m_rvalid` in the same cycle the counter hits its limit completes normally; no `o_busErr`.

## Structure
- Shared `mem_pkg` holds:
  - `dbus_state_t` enum (IDLE/REQ/RSP/DONE).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - `DBUS_TO_W` = 8.
- One sub-module, `mem_load_align`: purely combinational; (rdata, addr[1:0], funct3) -> extended word.
- `mem_top` instantiates `mem_dbus_ctrl` in the non-simulation memory path and ORs `o_stall` into the hazard unit.

## Test plan
- LW at 0x100, zero-wait bus, `m_rdata` = 0xDEADBEEF -> `m_addr` 0x100, `m_be` 0000, `o_stall` high for 3 cycles, `o_readData` = 0xDEADBEEF.
- LB at 0x103 with `m_rdata` = 0x80FF_0000 -> 0xFFFFFF80; LBU at the same address -> 0x00000080; LH at 0x102 -> 0xFFFF80FF.
- SH at 0x206, `i_wrData` = 0x1234ABCD -> `m_addr` 0x204, `m_be` 1100, `m_wdata` 0xABCDABCD; `m_ready` delayed 2 cycles -> 5 stall cycles.
- LW at 0x101 and SH at 0x3 -> `o_misaligned` = 1, `o_stall` = 0, `m_valid` never asserted, `o_readData` unchanged.
- `TIMEOUT_CYCLES` = 4 and `m_rvalid` never asserted -> `o_busErr` pulses once, `o_readData` = 0, FSM back in IDLE.
- Reset asserted while in RSP, then a late `m_rvalid` -> `m_valid` 0, FSM stays in IDLE, `o_readData` 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types, funct3 encodings and lane helpers for the MEM-stage data-bus controller.
package mem_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} dbus_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned DBUS_TO_W = 8;

  // Unsigned sizes only exist for loads; anything off its natural boundary is rejected.
  function automatic logic access_ok(logic [2:0] funct3, logic [1:0] off, logic is_write);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_write;
      F3_HU:   ok = ~is_write & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(logic [2:0] funct3, logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(logic [2:0] funct3, logic [31:0] wdata);
    logic [31:0] lanes;
    case (funct3)
      F3_B:    lanes = {4{wdata[7:0]}};
      F3_H:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_dbus_ctrl_if.sv
// Single-outstanding valid/ready data-memory bus between the MEM stage and memory.
interface mem_dbus_ctrl_if;
  logic        m_valid;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  modport master (
    output m_valid, m_write, m_addr, m_wdata, m_be,
    input  m_ready, m_rvalid, m_rdata
  );

  modport slave (
    input  m_valid, m_write, m_addr, m_wdata, m_be,
    output m_ready, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Byte-lane alignment and sign/zero extension of a loaded bus word.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: one outstanding load/store at a time, pipeline stalled
// until the bus responds or the access times out.
module mem_dbus_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [31:0]       i_memAddr,
  input  logic [31:0]       i_wrData,
  input  logic              i_memRead,
  input  logic              i_memWrite,
  input  logic [2:0]        i_funct3,
  output logic [31:0]       o_readData,
  output logic              o_stall,
  output logic              o_misaligned,
  output logic              o_busErr,
  mem_dbus_ctrl_if.master   bus
);

  localparam logic [DBUS_TO_W-1:0] TO_LAST = DBUS_TO_W'(TIMEOUT_CYCLES - 1);

  dbus_state_t          state_q;
  logic [DBUS_TO_W-1:0] cnt_q;
  logic [2:0]           f3_q;
  logic [1:0]           off_q;
  logic                 access;
  logic                 ok;
  logic                 to_hit;
  logic [31:0]          load_data;

  assign access = i_memRead | i_memWrite;
  assign ok     = access_ok(i_funct3, i_memAddr[1:0], i_memWrite);
  assign to_hit = (cnt_q == TO_LAST);

  // Gated by reset so a held request cannot stall the pipeline while the core is in reset.
  assign o_stall = i_reset_n & ((state_q == StIdle & access & ok) |
                                state_q == StReq | state_q == StRsp);
  assign o_misaligned = i_reset_n & (state_q == StIdle) & access & ~ok;

  mem_load_align u_load_align (
    .rdata  (bus.m_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      o_readData  <= '0;
      o_busErr    <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_write <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_be    <= '0;
    end else begin
      o_busErr <= 1'b0;
      case (state_q)
        StIdle: begin
          if (access && ok) begin
            state_q     <= StReq;
            cnt_q       <= '0;
            f3_q        <= i_funct3;
            off_q       <= i_memAddr[1:0];
            bus.m_valid <= 1'b1;
            bus.m_write <= i_memWrite;
            bus.m_addr  <= {i_memAddr[31:2], 2'b00};
            bus.m_be    <= i_memWrite ? byte_en(i_funct3, i_memAddr[1:0]) : 4'b0000;
            bus.m_wdata <= store_lanes(i_funct3, i_wrData);
          end
        end
        StReq: begin
          // Limit wins over a same-cycle handshake: no response could arrive in time anyway.
          if (to_hit) begin
            state_q     <= StDone;
            bus.m_valid <= 1'b0;
            o_busErr    <= 1'b1;
            if (!bus.m_write) o_readData <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (bus.m_ready) begin
              bus.m_valid <= 1'b0;
              state_q     <= StRsp;
            end
          end
        end
        StRsp: begin
          if (bus.m_rvalid) begin
            state_q <= StDone;
            if (!bus.m_write) o_readData <= load_data;
          end else if (to_hit) begin
            state_q  <= StDone;
            o_busErr <= 1'b1;
            if (!bus.m_write) o_readData <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed vector bench for mem_dbus_ctrl; a second instance with a short timeout covers bus errors.
module tb_mem_dbus_ctrl;
  import mem_pkg::*;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] mem_addr, wr_data;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic        sel;
  logic        tb_ready, tb_rvalid;
  logic [31:0] tb_rdata;

  logic [31:0] rd1, rd2;
  logic        stall1, stall2, mis1, mis2, err1, err2;

  mem_dbus_ctrl_if bus1 ();
  mem_dbus_ctrl_if bus2 ();

  assign bus1.m_ready  = tb_ready & ~sel;
  assign bus1.m_rvalid = tb_rvalid & ~sel;
  assign bus1.m_rdata  = tb_rdata;
  assign bus2.m_ready  = tb_ready & sel;
  assign bus2.m_rvalid = tb_rvalid & sel;
  assign bus2.m_rdata  = tb_rdata;

  mem_dbus_ctrl #(.TIMEOUT_CYCLES(255)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_memAddr(mem_addr), .i_wrData(wr_data),
    .i_memRead(mem_read & ~sel), .i_memWrite(mem_write & ~sel), .i_funct3(funct3),
    .o_readData(rd1), .o_stall(stall1), .o_misaligned(mis1), .o_busErr(err1), .bus(bus1)
  );

  mem_dbus_ctrl #(.TIMEOUT_CYCLES(4)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_memAddr(mem_addr), .i_wrData(wr_data),
    .i_memRead(mem_read & sel), .i_memWrite(mem_write & sel), .i_funct3(funct3),
    .o_readData(rd2), .o_stall(stall2), .o_misaligned(mis2), .o_busErr(err2), .bus(bus2)
  );

  logic        v_stall, v_mis, v_err, v_valid, v_write;
  logic [31:0] v_rdata, v_addr, v_wdata;
  logic [3:0]  v_be;
  assign v_stall = sel ? stall2 : stall1;
  assign v_mis   = sel ? mis2 : mis1;
  assign v_err   = sel ? err2 : err1;
  assign v_rdata = sel ? rd2 : rd1;
  assign v_valid = sel ? bus2.m_valid : bus1.m_valid;
  assign v_write = sel ? bus2.m_write : bus1.m_write;
  assign v_addr  = sel ? bus2.m_addr : bus1.m_addr;
  assign v_wdata = sel ? bus2.m_wdata : bus1.m_wdata;
  assign v_be    = sel ? bus2.m_be : bus1.m_be;

  typedef struct {
    logic        dut2;
    logic [31:0] addr, wdata, rdata;
    logic        rd, wr;
    logic [2:0]  f3;
    int          rdy_wait, rsp_wait;
    logic        early_rv;
    int          exp_stalls;
    logic        exp_mis, exp_valid, exp_write, exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rdata;
  } vec_t;

  vec_t vecs[20];

  int checks = 0;
  int passes = 0;

  int          r_stalls;
  logic        r_done, r_valid, r_write, r_mis, r_err, r_valid_after, r_err_after;
  logic [31:0] r_addr, r_wdata, r_rd;
  logic [3:0]  r_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Plays one access: bus slave inserts rdy_wait/rsp_wait idle cycles; stops on the first
  // non-stalled cycle (DONE, or IDLE for rejected/no access).
  task automatic do_access(input vec_t v);
    int   req_n, rsp_n;
    logic hs;
    req_n = 0; rsp_n = 0; hs = 1'b0;
    r_stalls = 0; r_done = 1'b0; r_valid = 1'b0; r_write = 1'b0; r_mis = 1'b0;
    r_err = 1'b0; r_addr = '0; r_wdata = '0; r_rd = '0; r_be = '0;
    @(negedge clk);
    mem_addr = v.addr; wr_data = v.wdata; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
    for (int c = 0; c < 64 && !r_done; c++) begin
      tb_ready = 1'b0; tb_rvalid = 1'b0; tb_rdata = 32'h5A5A5A5A;
      if (v_valid) begin
        if (!r_valid) begin
          r_valid = 1'b1; r_addr = v_addr; r_be = v_be; r_wdata = v_wdata; r_write = v_write;
        end
        if (req_n >= v.rdy_wait) begin
          tb_ready = 1'b1; hs = 1'b1;
          if (v.early_rv) begin tb_rvalid = 1'b1; tb_rdata = 32'hBAD0BAD0; end
        end
        req_n++;
      end else if (hs) begin
        if (rsp_n >= v.rsp_wait) begin tb_rvalid = 1'b1; tb_rdata = v.rdata; hs = 1'b0; end
        rsp_n++;
      end
      #1;
      if (v_stall) begin
        r_stalls++;
        @(negedge clk);
      end else begin
        r_done = 1'b1; r_mis = v_mis; r_rd = v_rdata; r_err = v_err;
      end
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; tb_ready = 1'b0; tb_rvalid = 1'b0;
    #1;
    r_valid_after = v_valid;
    r_err_after   = v_err;
  endtask

  initial begin
    vecs[0]  = '{N, 32'h100, 32'h0, 32'hDEADBEEF, Y, N, F3_W, 0, 0, N, 3, N, Y, N, N,
                 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF};
    vecs[1]  = '{N, 32'h103, 32'h0, 32'h80FF0000, Y, N, F3_B, 0, 0, N, 3, N, Y, N, N,
                 32'h100, 4'b0000, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{N, 32'h103, 32'h0, 32'h80FF0000, Y, N, F3_BU, 0, 0, N, 3, N, Y, N, N,
                 32'h100, 4'b0000, 32'h0, 32'h00000080};
    vecs[3]  = '{N, 32'h102, 32'h0, 32'h80FF0000, Y, N, F3_H, 0, 0, N, 3, N, Y, N, N,
                 32'h100, 4'b0000, 32'h0, 32'hFFFF80FF};
    vecs[4]  = '{N, 32'h206, 32'h1234ABCD, 32'h0, N, Y, F3_H, 2, 0, N, 5, N, Y, Y, N,
                 32'h204, 4'b1100, 32'hABCDABCD, 32'hFFFF80FF};
    vecs[5]  = '{N, 32'h101, 32'h0, 32'h12345678, Y, N, F3_W, 0, 0, N, 0, Y, N, N, N,
                 32'h0, 4'b0000, 32'h0, 32'hFFFF80FF};
    vecs[6]  = '{N, 32'h3, 32'hFFFF, 32'h0, N, Y, F3_H, 0, 0, N, 0, Y, N, N, N,
                 32'h0, 4'b0000, 32'h0, 32'hFFFF80FF};
    vecs[7]  = '{N, 32'h101, 32'hA5, 32'h0, N, Y, F3_B, 0, 1, N, 4, N, Y, Y, N,
                 32'h100, 4'b0010, 32'hA5A5A5A5, 32'hFFFF80FF};
    vecs[8]  = '{N, 32'h10, 32'hCAFEF00D, 32'h0, N, Y, F3_W, 0, 0, N, 3, N, Y, Y, N,
                 32'h10, 4'b1111, 32'hCAFEF00D, 32'hFFFF80FF};
    vecs[9]  = '{N, 32'h2, 32'h0, 32'h80017FFF, Y, N, F3_HU, 0, 0, N, 3, N, Y, N, N,
                 32'h0, 4'b0000, 32'h0, 32'h00008001};
    vecs[10] = '{N, 32'h0, 32'h0, 32'h12348001, Y, N, F3_H, 1, 1, N, 5, N, Y, N, N,
                 32'h0, 4'b0000, 32'h0, 32'hFFFF8001};
    vecs[11] = '{N, 32'h1, 32'h0, 32'h00007F00, Y, N, F3_B, 0, 0, N, 3, N, Y, N, N,
                 32'h0, 4'b0000, 32'h0, 32'h0000007F};
    vecs[12] = '{N, 32'h0, 32'h99, 32'h0, N, Y, F3_BU, 0, 0, N, 0, Y, N, N, N,
                 32'h0, 4'b0000, 32'h0, 32'h0000007F};
    vecs[13] = '{N, 32'h0, 32'h0, 32'h1, Y, N, 3'b011, 0, 0, N, 0, Y, N, N, N,
                 32'h0, 4'b0000, 32'h0, 32'h0000007F};
    vecs[14] = '{N, 32'h20, 32'h5555AAAA, 32'h0, Y, Y, F3_W, 0, 0, N, 3, N, Y, Y, N,
                 32'h20, 4'b1111, 32'h5555AAAA, 32'h0000007F};
    vecs[15] = '{N, 32'h40, 32'h0, 32'h0, N, N, F3_W, 0, 0, N, 0, N, N, N, N,
                 32'h0, 4'b0000, 32'h0, 32'h0000007F};
    vecs[16] = '{N, 32'h30, 32'h0, 32'h0BADCAFE, Y, N, F3_W, 0, 1, Y, 4, N, Y, N, N,
                 32'h30, 4'b0000, 32'h0, 32'h0BADCAFE};
    vecs[17] = '{Y, 32'h44, 32'h0, 32'h11223344, Y, N, F3_W, 0, 2, N, 5, N, Y, N, N,
                 32'h44, 4'b0000, 32'h0, 32'h11223344};
    vecs[18] = '{Y, 32'h48, 32'h0, 32'h55667788, Y, N, F3_W, 0, 1000, N, 5, N, Y, N, Y,
                 32'h48, 4'b0000, 32'h0, 32'h0};
    vecs[19] = '{Y, 32'h4B, 32'h0, 32'hAB000000, Y, N, F3_BU, 0, 0, N, 3, N, Y, N, N,
                 32'h48, 4'b0000, 32'h0, 32'h000000AB};

    rst_n = 1'b0; sel = 1'b0; mem_addr = '0; wr_data = '0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = F3_W; tb_ready = 1'b0; tb_rvalid = 1'b0; tb_rdata = '0;

    #12;
    chk("rst_readData", rd1, 32'h0);
    chk("rst_valid", 32'(bus1.m_valid), 32'h0);
    chk("rst_write", 32'(bus1.m_write), 32'h0);
    chk("rst_addr", bus1.m_addr, 32'h0);
    chk("rst_wdata", bus1.m_wdata, 32'h0);
    chk("rst_be", 32'(bus1.m_be), 32'h0);
    chk("rst_busErr", 32'(err1), 32'h0);
    mem_read = 1'b1; funct3 = 3'b011;
    #1;
    chk("rst_stall", 32'(stall1), 32'h0);
    chk("rst_misaligned", 32'(mis1), 32'h0);
    mem_read = 1'b0; funct3 = F3_W;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      sel = vecs[i].dut2;
      do_access(vecs[i]);
      chk($sformatf("v%0d_done", i), 32'(r_done), 32'h1);
      chk($sformatf("v%0d_stalls", i), r_stalls, vecs[i].exp_stalls);
      chk($sformatf("v%0d_misaligned", i), 32'(r_mis), 32'(vecs[i].exp_mis));
      chk($sformatf("v%0d_valid_seen", i), 32'(r_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_valid_after", i), 32'(r_valid_after), 32'h0);
      chk($sformatf("v%0d_busErr", i), 32'(r_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_busErr_after", i), 32'(r_err_after), 32'h0);
      chk($sformatf("v%0d_readData", i), r_rd, vecs[i].exp_rdata);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_addr", i), r_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_be", i), 32'(r_be), 32'(vecs[i].exp_be));
        chk($sformatf("v%0d_write", i), 32'(r_write), 32'(vecs[i].exp_write));
      end
      if (vecs[i].exp_write) chk($sformatf("v%0d_wdata", i), r_wdata, vecs[i].exp_wdata);
    end

    // Reset while waiting in RSP, followed by a stale response.
    sel = 1'b0;
    @(negedge clk);
    mem_addr = 32'h80; funct3 = F3_W; mem_read = 1'b1;
    @(negedge clk);
    #1;
    chk("rstseq_req_valid", 32'(bus1.m_valid), 32'h1);
    tb_ready = 1'b1;
    @(negedge clk);
    tb_ready = 1'b0;
    #1;
    chk("rstseq_rsp_stall", 32'(stall1), 32'h1);
    chk("rstseq_rsp_valid", 32'(bus1.m_valid), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstseq_in_reset_valid", 32'(bus1.m_valid), 32'h0);
    chk("rstseq_in_reset_stall", 32'(stall1), 32'h0);
    chk("rstseq_in_reset_readData", rd1, 32'h0);
    @(negedge clk);
    mem_read = 1'b0; rst_n = 1'b1;
    tb_rvalid = 1'b1; tb_rdata = 32'h77777777;
    repeat (3) @(negedge clk);
    #1;
    chk("rstseq_late_valid", 32'(bus1.m_valid), 32'h0);
    chk("rstseq_late_stall", 32'(stall1), 32'h0);
    chk("rstseq_late_readData", rd1, 32'h0);
    tb_rvalid = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
